alu_issue_stage: RTL and testbench

Two-stage pipelined issue/retire wrapper around the 16-bit combinational ALU. It accepts operation requests with a valid/ready handshake and decodes a 4-bit function code into the ALU control lines (invert A, invert B, 2-bit operation). It presents registered operands to the ALU and captures result, zero and overflow into an output register with its own valid/ready handshake. It sits between the datapath's operand-fetch logic (upstream) and the writeback/flag logic (downstream).

---
 rtl/alu_issue_stage_if.sv | 58 +++++
 rtl/alu_issue_stage.sv | 173 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage_if
// Description : Bundles the request, ALU-facing, result and overflow-status
//               signals of the ALU issue/retire stage.
//               slave  - seen from the issue stage
//               master - seen from the surrounding datapath
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if;
    // upstream request
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_func;
    logic [15:0] in_a;
    logic [15:0] in_b;
    // combinational ALU
    logic [15:0] alu_src1;
    logic [15:0] alu_src2;
    logic        alu_invert_a;
    logic        alu_invert_b;
    logic [1:0]  alu_operation;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    // downstream result
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_zero;
    logic        out_ovf;
    logic        out_err;
    // overflow statistics
    logic        ovf_clr;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;

    modport slave (
        input  in_valid, in_func, in_a, in_b,
        input  alu_result, alu_zero, alu_overflow,
        input  out_ready, ovf_clr,
        output in_ready,
        output alu_src1, alu_src2, alu_invert_a, alu_invert_b, alu_operation,
        output out_valid, out_result, out_zero, out_ovf, out_err,
        output ovf_sticky, ovf_count
    );

    modport master (
        output in_valid, in_func, in_a, in_b,
        output alu_result, alu_zero, alu_overflow,
        output out_ready, ovf_clr,
        input  in_ready,
        input  alu_src1, alu_src2, alu_invert_a, alu_invert_b, alu_operation,
        input  out_valid, out_result, out_zero, out_ovf, out_err,
        input  ovf_sticky, ovf_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Two-stage issue/retire wrapper around a 16-bit combinational
//               ALU. S1 holds the decoded request and drives the ALU; S2
//               captures result and flags behind a valid/ready handshake.
//               Optional overflow statistics: define ALU_ISSUE_OVF_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_stage_if.slave bus
);

    localparam logic [3:0] c_FN_AND  = 4'd0;
    localparam logic [3:0] c_FN_OR   = 4'd1;
    localparam logic [3:0] c_FN_ADD  = 4'd2;
    localparam logic [3:0] c_FN_SUB  = 4'd3;
    localparam logic [3:0] c_FN_SLT  = 4'd4;
    localparam logic [3:0] c_FN_NOR  = 4'd5;
    localparam logic [3:0] c_FN_NAND = 4'd6;

    // decoded request
    logic        w_inv_a;
    logic        w_inv_b;
    logic [1:0]  w_op;
    logic        w_illegal;
    logic        w_arith;

    // S1 issue register
    logic        r_s1_valid;
    logic        r_s1_inv_a;
    logic        r_s1_inv_b;
    logic [1:0]  r_s1_op;
    logic [15:0] r_s1_a;
    logic [15:0] r_s1_b;
    logic        r_s1_illegal;
    logic        r_s1_arith;

    // S2 retire register
    logic        r_s2_valid;
    logic [15:0] r_s2_result;
    logic        r_s2_zero;
    logic        r_s2_ovf;
    logic        r_s2_err;

    logic        w_in_ready;
    logic        w_s1_load;
    logic        w_s2_load;
    logic        w_ovf_event;

    // Function code to ALU control lines; illegal codes leave all controls low
    always_comb begin
        w_inv_a   = 1'b0;
        w_inv_b   = 1'b0;
        w_op      = 2'b00;
        w_illegal = 1'b0;
        w_arith   = 1'b0;
        case (bus.in_func)
            c_FN_AND:  w_op = 2'b00;
            c_FN_OR:   w_op = 2'b01;
            c_FN_ADD:  begin w_op = 2'b10; w_arith = 1'b1; end
            c_FN_SUB:  begin w_inv_b = 1'b1; w_op = 2'b10; w_arith = 1'b1; end
            c_FN_SLT:  begin w_inv_b = 1'b1; w_op = 2'b11; end
            c_FN_NOR:  begin w_inv_a = 1'b1; w_inv_b = 1'b1; w_op = 2'b00; end
            c_FN_NAND: begin w_inv_a = 1'b1; w_inv_b = 1'b1; w_op = 2'b01; end
            default:   w_illegal = 1'b1;
        endcase
    end

    // S2 can take from S1 whenever it is empty or being drained this cycle;
    // in_ready deliberately does not look at in_valid.
    assign w_s2_load  = r_s1_valid & (~r_s2_valid | bus.out_ready);
    assign w_in_ready = ~r_s1_valid | ~r_s2_valid | bus.out_ready;
    assign w_s1_load  = bus.in_valid & w_in_ready;
    // arith tag is only set for legal ADD/SUB, so illegal requests never count
    assign w_ovf_event = w_s2_load & r_s1_arith & bus.alu_overflow;

    // S1 issue register: load on accept, empty when its content moves to S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_inv_a   <= 1'b0;
            r_s1_inv_b   <= 1'b0;
            r_s1_op      <= 2'b00;
            r_s1_a       <= 16'h0000;
            r_s1_b       <= 16'h0000;
            r_s1_illegal <= 1'b0;
            r_s1_arith   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid   <= 1'b1;
            r_s1_inv_a   <= w_inv_a;
            r_s1_inv_b   <= w_inv_b;
            r_s1_op      <= w_op;
            r_s1_a       <= bus.in_a;
            r_s1_b       <= bus.in_b;
            r_s1_illegal <= w_illegal;
            r_s1_arith   <= w_arith;
        end else if (w_s2_load) begin
            r_s1_valid   <= 1'b0;
        end
    end

    // S2 retire register: capture ALU outputs, or the forced illegal pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= 16'h0000;
            r_s2_zero   <= 1'b0;
            r_s2_ovf    <= 1'b0;
            r_s2_err    <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            if (r_s1_illegal) begin
                r_s2_result <= 16'h0000;
                r_s2_zero   <= 1'b1;
                r_s2_ovf    <= 1'b0;
                r_s2_err    <= 1'b1;
            end else begin
                r_s2_result <= bus.alu_result;
                r_s2_zero   <= bus.alu_zero;
                r_s2_ovf    <= r_s1_arith & bus.alu_overflow;
                r_s2_err    <= 1'b0;
            end
        end else if (bus.out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.alu_src1      = r_s1_valid ? r_s1_a     : 16'h0000;
    assign bus.alu_src2      = r_s1_valid ? r_s1_b     : 16'h0000;
    assign bus.alu_invert_a  = r_s1_valid & r_s1_inv_a;
    assign bus.alu_invert_b  = r_s1_valid & r_s1_inv_b;
    assign bus.alu_operation = r_s1_valid ? r_s1_op    : 2'b00;
    assign bus.out_valid     = r_s2_valid;
    assign bus.out_result    = r_s2_result;
    assign bus.out_zero      = r_s2_zero;
    assign bus.out_ovf       = r_s2_ovf;
    assign bus.out_err       = r_s2_err;

`ifdef ALU_ISSUE_OVF_STATS_EN
    logic       r_ovf_sticky;
    logic [7:0] r_ovf_count;

    // Overflow statistics; a clear coinciding with an event leaves that event counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_count  <= 8'd0;
        end else if (bus.ovf_clr) begin
            r_ovf_sticky <= w_ovf_event;
            r_ovf_count  <= w_ovf_event ? 8'd1 : 8'd0;
        end else if (w_ovf_event) begin
            r_ovf_sticky <= 1'b1;
            if (r_ovf_count != 8'hFF) begin
                r_ovf_count <= r_ovf_count + 8'd1;
            end
        end
    end

    assign bus.ovf_sticky = r_ovf_sticky;
    assign bus.ovf_count  = r_ovf_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = bus.ovf_clr ^ w_ovf_event;
    assign bus.ovf_sticky = 1'b0;
    assign bus.ovf_count  = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Bench for alu_issue_stage with an attached behavioural ALU,
//               a function-level reference model and directed plus random
//               stimulus. Honours ALU_ISSUE_OVF_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_OVF_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Combinational ALU attached to the stage (adder overflow always shown)
    // ------------------------------------------------------------------
    logic [15:0] alu_x, alu_y;
    logic [16:0] alu_s;
    logic        alu_v;
    logic [15:0] alu_r;
    always_comb begin
        alu_x = bus.alu_invert_a ? ~bus.alu_src1 : bus.alu_src1;
        alu_y = bus.alu_invert_b ? ~bus.alu_src2 : bus.alu_src2;
        alu_s = {1'b0, alu_x} + {1'b0, alu_y} + {16'd0, bus.alu_invert_b};
        alu_v = (alu_x[15] == alu_y[15]) && (alu_s[15] != alu_x[15]);
        case (bus.alu_operation)
            2'b00:   alu_r = alu_x & alu_y;
            2'b01:   alu_r = alu_x | alu_y;
            2'b10:   alu_r = alu_s[15:0];
            default: alu_r = {15'd0, alu_s[15] ^ alu_v};
        endcase
        bus.alu_result   = alu_r;
        bus.alu_zero     = (alu_r == 16'h0000);
        bus.alu_overflow = alu_v;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        v;
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        z;
        logic        o;
        logic        e;
    } item_t;

    typedef struct {
        logic [15:0] r;
        logic        z;
        logic        o;
        logic        e;
        int          cyc;
    } rec_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    rec_t log_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void exec(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic z, output logic o,
                                 output logic e);
        int sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        s  = 0;
        o  = 1'b0;
        e  = 1'b0;
        case (f)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin s = sa + sb; r = a + b; o = (s > 32767) || (s < -32768); end
            4'd3: begin s = sa - sb; r = a - b; o = (s > 32767) || (s < -32768); end
            4'd4: r = (sa < sb) ? 16'd1 : 16'd0;
            4'd5: r = ~(a | b);
            4'd6: r = ~(a & b);
            default: begin r = 16'h0000; e = 1'b1; end
        endcase
        z = (r == 16'h0000);
    endfunction

    function automatic logic [3:0] ctrl(input logic [3:0] f);
        case (f)
            4'd0:    return 4'b0000;
            4'd1:    return 4'b0001;
            4'd2:    return 4'b0010;
            4'd3:    return 4'b0110;
            4'd4:    return 4'b0111;
            4'd5:    return 4'b1100;
            4'd6:    return 4'b1101;
            default: return 4'b0000;
        endcase
    endfunction

    // Per-cycle compare against the model, then advance the model to the next edge
    initial begin
        item_t m1, m2;
        logic  st;
        int    cnt;
        logic  exp_rdy, out_fire, take, in_fire, ev;
        logic [15:0] r;
        logic z, o, e;
        m1 = '0; m2 = '0; st = 1'b0; cnt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m1 = '0; m2 = '0; st = 1'b0; cnt = 0;
                chk("rst_out_valid", bus.out_valid, 0);
                chk("rst_in_ready", bus.in_ready, 1);
                chk("rst_out_flags", {bus.out_result, bus.out_zero, bus.out_ovf, bus.out_err}, 0);
                chk("rst_alu_ctrl", {bus.alu_invert_a, bus.alu_invert_b, bus.alu_operation}, 0);
                chk("rst_alu_src", {bus.alu_src1, bus.alu_src2}, 0);
                chk("rst_stats", {bus.ovf_sticky, bus.ovf_count}, 0);
            end else begin
                exp_rdy = !(m1.v && m2.v && !bus.out_ready);
                chk("in_ready", bus.in_ready, exp_rdy);
                chk("out_valid", bus.out_valid, m2.v);
                if (m2.v) begin
                    chk("out_result", bus.out_result, m2.r);
                    chk("out_flags", {bus.out_zero, bus.out_ovf, bus.out_err}, {m2.z, m2.o, m2.e});
                end
                chk("alu_ctrl", {bus.alu_invert_a, bus.alu_invert_b, bus.alu_operation},
                    m1.v ? ctrl(m1.f) : 4'b0000);
                chk("alu_src", {bus.alu_src1, bus.alu_src2}, m1.v ? {m1.a, m1.b} : 32'd0);
                chk("ovf_stats", {bus.ovf_sticky, bus.ovf_count}, {st, cnt[7:0]});
                if (bus.out_valid && bus.out_ready)
                    log_q.push_back('{bus.out_result, bus.out_zero, bus.out_ovf, bus.out_err, cyc});

                out_fire = m2.v && bus.out_ready;
                take     = m1.v && (!m2.v || bus.out_ready);
                in_fire  = bus.in_valid && exp_rdy;
                ev       = take && m1.o;
                if (c_STATS) begin
                    if (bus.ovf_clr) begin
                        st  = ev;
                        cnt = ev ? 1 : 0;
                    end else if (ev) begin
                        st  = 1'b1;
                        cnt = (cnt + 1 > 255) ? 255 : cnt + 1;
                    end
                end
                if (take)          m2 = m1;
                else if (out_fire) m2.v = 1'b0;
                if (in_fire) begin
                    exec(bus.in_func, bus.in_a, bus.in_b, r, z, o, e);
                    m1 = '{1'b1, bus.in_func, bus.in_a, bus.in_b, r, z, o, e};
                end else if (take) begin
                    m1.v = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        logic acc;
        bus.in_valid = 1'b1;
        bus.in_func  = f;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        chk("send_timeout", 0, 1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0]  bp_f [4] = '{4'd2, 4'd1, 4'd0, 4'd3};
    logic [15:0] bp_a [4] = '{16'h0001, 16'h00F0, 16'hF0F0, 16'h0005};
    logic [15:0] bp_b [4] = '{16'h0002, 16'h0F00, 16'hFF00, 16'h0007};
    logic [15:0] bp_r [4] = '{16'h0003, 16'h0FF0, 16'hF000, 16'hFFFE};

    task automatic bp_run(input int cycles, inout int idx);
        logic acc;
        for (int c = 0; c < cycles; c++) begin
            if (idx < 4) begin
                bus.in_valid = 1'b1;
                bus.in_func  = bp_f[idx];
                bus.in_a     = bp_a[idx];
                bus.in_b     = bp_b[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc && idx < 4) idx++;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int idx;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_func  = 4'd0;
        bus.in_a     = 16'h0000;
        bus.in_b     = 16'h0000;
        bus.out_ready = 1'b1;
        bus.ovf_clr  = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);

        // ADD overflow: latency and literal result
        send(4'd2, 16'h7FFF, 16'h0001);
        @(negedge clk);
        chk("add_lat_s1_only", bus.out_valid, 0);
        chk("add_ctrl", {bus.alu_invert_a, bus.alu_invert_b, bus.alu_operation}, 4'b0010);
        @(negedge clk);
        chk("add_lat_out", bus.out_valid, 1);
        chk("add_result", bus.out_result, 16'h8000);
        chk("add_flags", {bus.out_zero, bus.out_ovf, bus.out_err}, 3'b010);
        step(2);

        // SUB then SLT back-to-back
        log_q.delete();
        send(4'd3, 16'h1234, 16'h1234);
        send(4'd4, 16'hFFFF, 16'h0001);
        step(4);
        chk("subslt_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            chk("sub_out", {log_q[0].r, log_q[0].z, log_q[0].o, log_q[0].e}, {16'h0000, 3'b100});
            chk("slt_out", {log_q[1].r, log_q[1].z, log_q[1].o, log_q[1].e}, {16'h0001, 3'b000});
            chk("subslt_consecutive", log_q[1].cyc - log_q[0].cyc, 1);
        end

        // NOR / NAND controls and results
        log_q.delete();
        send(4'd5, 16'h00FF, 16'h0F00);
        @(negedge clk);
        chk("nor_ctrl", {bus.alu_invert_a, bus.alu_invert_b, bus.alu_operation}, 4'b1100);
        step(1);
        send(4'd6, 16'hFFFF, 16'hFFFF);
        @(negedge clk);
        chk("nand_ctrl", {bus.alu_invert_a, bus.alu_invert_b, bus.alu_operation}, 4'b1101);
        step(3);
        chk("nornand_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            chk("nor_out", {log_q[0].r, log_q[0].z}, {16'hF000, 1'b0});
            chk("nand_out", {log_q[1].r, log_q[1].z}, {16'h0000, 1'b1});
        end

        // Illegal function code
        log_q.delete();
        send(4'b1010, 16'h1357, 16'h2468);
        @(negedge clk);
        chk("illegal_ctrl", {bus.alu_invert_a, bus.alu_invert_b, bus.alu_operation}, 4'b0000);
        step(3);
        chk("illegal_count", log_q.size(), 1);
        if (log_q.size() >= 1)
            chk("illegal_out", {log_q[0].r, log_q[0].z, log_q[0].o, log_q[0].e}, {16'h0000, 3'b101});

        // Backpressure: two accepts, stable output, then ordered release
        log_q.delete();
        bus.out_ready = 1'b0;
        idx = 0;
        bp_run(8, idx);
        chk("bp_accepts", idx, 2);
        chk("bp_hold_result", bus.out_result, 16'h0003);
        bus.out_ready = 1'b1;
        bp_run(12, idx);
        step(3);
        chk("bp_all_accepted", idx, 4);
        chk("bp_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (log_q.size() > i) chk("bp_order", log_q[i].r, bp_r[i]);

        // Reset mid-stream drops everything in flight
        bus.out_ready = 1'b0;
        send(4'd2, 16'h0001, 16'h0001);
        send(4'd2, 16'h0002, 16'h0002);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {bus.out_valid, bus.in_ready}, 2'b01);
        chk("midrst_alu", {bus.alu_operation, bus.alu_src1}, 0);
        step(2);
        rst_n = 1'b1;
        log_q.delete();
        bus.out_ready = 1'b1;
        step(4);
        chk("midrst_no_replay", log_q.size(), 0);

        // Overflow statistics: saturation and coincident clear
        for (int i = 0; i < 300; i++) send(4'd2, 16'h7FFF, 16'h0001);
        step(3);
        chk("stats_sat_count", bus.ovf_count, c_STATS ? 8'd255 : 8'd0);
        chk("stats_sat_sticky", bus.ovf_sticky, c_STATS);
        send(4'd2, 16'h8000, 16'hFFFF);
        bus.ovf_clr = 1'b1;
        step(1);
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        chk("stats_clr_count", bus.ovf_count, c_STATS ? 8'd1 : 8'd0);
        chk("stats_clr_sticky", bus.ovf_sticky, c_STATS);
        step(1);

        // Randomised traffic checked cycle by cycle against the model
        repeat (800) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_func   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15))
                                                        : 4'($urandom_range(0, 6));
            bus.in_a      = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
            bus.in_b      = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.ovf_clr   = ($urandom_range(0, 15) == 0);
            step(1);
        end
        bus.in_valid  = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.out_ready = 1'b1;
        step(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
